// File: rtl/exec_if.sv
// Issue/write-back bundle between the execute stage and the register file.
// The master side issues operations; the slave side is the execute unit.
interface exec_if #(parameter int WIDTH = 32);
  logic             start;
  logic [1:0]       op;
  logic [WIDTH-1:0] srcA;
  logic [WIDTH-1:0] srcB;
  logic [1:0]       dstReg;
  logic             busy;
  logic             writeEnable;
  logic [1:0]       writeReg;
  logic [WIDTH-1:0] writeData;
  logic             overflow;

  modport master (output start, op, srcA, srcB, dstReg,
                  input  busy, writeEnable, writeReg, writeData, overflow);
  modport slave  (input  start, op, srcA, srcB, dstReg,
                  output busy, writeEnable, writeReg, writeData, overflow);
endinterface

// File: rtl/exec_unit.sv
// Execute stage: ADD/SUB/AND single-cycle, op 11 is a 32-step shift-add MUL when
// EXEC_MUL_EN is defined, otherwise a single-cycle XOR. Result leaves as a one-cycle write strobe.
module exec_unit #(parameter int WIDTH = 32) (
  input  logic   clk,
  input  logic   reset,
  exec_if.slave  bus
);

`ifdef EXEC_MUL_EN
  typedef enum logic [1:0] {S_IDLE, S_MUL, S_WB} state_t;
`else
  typedef enum logic [1:0] {S_IDLE, S_WB} state_t;
`endif

  state_t           state_q, state_d;
  logic             busy_q, busy_d;
  logic             we_q, we_d;
  logic [1:0]       wreg_q, wreg_d;
  logic [WIDTH-1:0] wdata_q, wdata_d;
  logic             ovf_q, ovf_d;
  logic [1:0]       op_q, op_d;
  logic [WIDTH-1:0] a_q, a_d;
  logic [WIDTH-1:0] b_q, b_d;
  logic [1:0]       dst_q, dst_d;
  logic [WIDTH-1:0] res;
  logic             res_ovf;
  logic [WIDTH-1:0] sum_ab, diff_ab;
`ifdef EXEC_MUL_EN
  logic [2*WIDTH-1:0] prod_q, prod_d;
  logic [4:0]         cnt_q, cnt_d;
  logic [WIDTH:0]     mul_sum;
`endif

  assign sum_ab  = a_q + b_q;
  assign diff_ab = a_q - b_q;

  always_comb begin
    res     = '0;
    res_ovf = 1'b0;
    case (op_q)
      2'b00: begin
        res     = sum_ab;
        res_ovf = (a_q[WIDTH-1] == b_q[WIDTH-1]) && (sum_ab[WIDTH-1] != a_q[WIDTH-1]);
      end
      2'b01: begin
        res     = diff_ab;
        res_ovf = (a_q[WIDTH-1] != b_q[WIDTH-1]) && (diff_ab[WIDTH-1] != a_q[WIDTH-1]);
      end
      2'b10: res = a_q & b_q;
      default: begin
`ifdef EXEC_MUL_EN
        res     = prod_q[WIDTH-1:0];
        res_ovf = |prod_q[2*WIDTH-1:WIDTH];
`else
        res     = a_q ^ b_q;
`endif
      end
    endcase
  end

`ifdef EXEC_MUL_EN
  // b_q doubles as the multiplier shift register during MUL.
  assign mul_sum = {1'b0, prod_q[2*WIDTH-1:WIDTH]} + (b_q[0] ? {1'b0, a_q} : '0);
`endif

  // IDLE with busy set is the finalise cycle: the result is registered and the strobe raised.
  always_comb begin
    state_d = state_q;
    busy_d  = busy_q;
    we_d    = 1'b0;
    wreg_d  = wreg_q;
    wdata_d = wdata_q;
    ovf_d   = ovf_q;
    op_d    = op_q;
    a_d     = a_q;
    b_d     = b_q;
    dst_d   = dst_q;
`ifdef EXEC_MUL_EN
    prod_d  = prod_q;
    cnt_d   = cnt_q;
`endif
    case (state_q)
      S_IDLE: begin
        if (!busy_q) begin
          if (bus.start) begin
            busy_d = 1'b1;
            op_d   = bus.op;
            a_d    = bus.srcA;
            b_d    = bus.srcB;
            dst_d  = bus.dstReg;
`ifdef EXEC_MUL_EN
            if (bus.op == 2'b11) begin
              prod_d  = '0;
              cnt_d   = '0;
              state_d = S_MUL;
            end
`endif
          end
        end else begin
          we_d    = 1'b1;
          wreg_d  = dst_q;
          wdata_d = res;
          ovf_d   = res_ovf;
          state_d = S_WB;
        end
      end
`ifdef EXEC_MUL_EN
      S_MUL: begin
        prod_d = {mul_sum, prod_q[WIDTH-1:1]};
        b_d    = b_q >> 1;
        cnt_d  = cnt_q + 5'd1;
        if (cnt_q == 5'd31) state_d = S_IDLE;
      end
`endif
      S_WB: begin
        busy_d  = 1'b0;
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= S_IDLE;
      busy_q  <= 1'b0;
      we_q    <= 1'b0;
      wreg_q  <= '0;
      wdata_q <= '0;
      ovf_q   <= 1'b0;
      op_q    <= '0;
      a_q     <= '0;
      b_q     <= '0;
      dst_q   <= '0;
`ifdef EXEC_MUL_EN
      prod_q  <= '0;
      cnt_q   <= '0;
`endif
    end else begin
      state_q <= state_d;
      busy_q  <= busy_d;
      we_q    <= we_d;
      wreg_q  <= wreg_d;
      wdata_q <= wdata_d;
      ovf_q   <= ovf_d;
      op_q    <= op_d;
      a_q     <= a_d;
      b_q     <= b_d;
      dst_q   <= dst_d;
`ifdef EXEC_MUL_EN
      prod_q  <= prod_d;
      cnt_q   <= cnt_d;
`endif
    end
  end

  assign bus.busy        = busy_q;
  assign bus.writeEnable = we_q;
  assign bus.writeReg    = wreg_q;
  assign bus.writeData   = wdata_q;
  assign bus.overflow    = ovf_q;

endmodule

// File: tb/tb_exec_unit.sv
// Directed bench for exec_unit; MUL vectors apply when EXEC_MUL_EN is defined, XOR otherwise.
module tb_exec_unit;
  logic clk = 1'b0;
  logic reset = 1'b1;
  int   n_cmp = 0;
  int   n_err = 0;

  exec_if #(.WIDTH(32)) bus ();
  exec_unit #(.WIDTH(32)) dut (.clk(clk), .reset(reset), .bus(bus));

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Issue one op and follow it to write-back; operands are scrambled while busy.
  task automatic run_op(input string tag, input logic [1:0] op, input logic [31:0] a,
                        input logic [31:0] b, input logic [1:0] dst,
                        input logic [31:0] exp_data, input logic exp_ovf, input int exp_lat);
    int lat;
    bus.start = 1'b1; bus.op = op; bus.srcA = a; bus.srcB = b; bus.dstReg = dst;
    tick();
    bus.start = 1'b0;
    bus.srcA = ~a; bus.srcB = a ^ 32'h5A5A_5A5A; bus.op = ~op; bus.dstReg = ~dst;
    check({tag, "_busy"}, 64'(bus.busy), 64'(1'b1));
    lat = 0;
    while (!bus.writeEnable && lat < 40) begin
      tick();
      lat++;
    end
    check({tag, "_we"},   64'(bus.writeEnable), 64'(1'b1));
    check({tag, "_lat"},  64'(lat), 64'(exp_lat));
    check({tag, "_reg"},  64'(bus.writeReg), 64'(dst));
    check({tag, "_data"}, 64'(bus.writeData), 64'(exp_data));
    check({tag, "_ovf"},  64'(bus.overflow), 64'(exp_ovf));
    tick();
    check({tag, "_we_off"},  64'(bus.writeEnable), 64'(1'b0));
    check({tag, "_busy_off"}, 64'(bus.busy), 64'(1'b0));
    check({tag, "_hold"},    64'(bus.writeData), 64'(exp_data));
  endtask

  initial begin
    int pulses;
    int lat;
    logic [31:0] data;
    bus.start = 1'b0; bus.op = 2'b00; bus.srcA = '0; bus.srcB = '0; bus.dstReg = '0;

    #12;
    check("rst_busy", 64'(bus.busy), 64'(1'b0));
    check("rst_we",   64'(bus.writeEnable), 64'(1'b0));
    check("rst_reg",  64'(bus.writeReg), 64'(2'd0));
    check("rst_data", 64'(bus.writeData), 64'(32'd0));
    check("rst_ovf",  64'(bus.overflow), 64'(1'b0));
    @(negedge clk); reset = 1'b0;

    pulses = 0;
    for (int c = 0; c < 10; c++) begin
      tick();
      if (bus.writeEnable) pulses++;
    end
    check("idle_no_we", 64'(pulses), 64'(0));

    run_op("add_ovf", 2'b00, 32'h7FFF_FFFF, 32'h1, 2'd2, 32'h8000_0000, 1'b1, 1);
    run_op("sub",     2'b01, 32'd5, 32'd7, 2'd1, 32'hFFFF_FFFE, 1'b0, 1);
    run_op("sub_ovf", 2'b01, 32'h8000_0000, 32'h1, 2'd3, 32'h7FFF_FFFF, 1'b1, 1);
    run_op("and",     2'b10, 32'hF0F0_F0F0, 32'h0FF0_0FF0, 2'd0, 32'h00F0_00F0, 1'b0, 1);
`ifdef EXEC_MUL_EN
    run_op("mul",     2'b11, 32'd12345, 32'd678, 2'd3, 32'h007F_B6F6, 1'b0, 33);
    run_op("mul_hi",  2'b11, 32'h1_0000, 32'h1_0000, 2'd1, 32'h0, 1'b1, 33);
    run_op("mul_max", 2'b11, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 2'd2, 32'h1, 1'b1, 33);
`else
    run_op("xor",     2'b11, 32'hFF00_FF00, 32'h0F0F_0F0F, 2'd1, 32'hF00F_F00F, 1'b0, 1);
`endif

    // Reset asserted mid-cycle during write-back drops the strobe at once.
    bus.start = 1'b1; bus.op = 2'b00; bus.srcA = 32'd100; bus.srcB = 32'd1; bus.dstReg = 2'd3;
    tick();
    bus.start = 1'b0;
    tick();
    check("wb_we", 64'(bus.writeEnable), 64'(1'b1));
    #2 reset = 1'b1;
    #1;
    check("wb_rst_we",   64'(bus.writeEnable), 64'(1'b0));
    check("wb_rst_busy", 64'(bus.busy), 64'(1'b0));
    check("wb_rst_data", 64'(bus.writeData), 64'(32'd0));
    check("wb_rst_reg",  64'(bus.writeReg), 64'(2'd0));
    @(negedge clk); reset = 1'b0;

    // Start pulses while busy and a srcA change must not disturb the in-flight op.
    bus.start = 1'b1; bus.dstReg = 2'd2;
`ifdef EXEC_MUL_EN
    bus.op = 2'b11; bus.srcA = 32'd1000; bus.srcB = 32'd3000;
`else
    bus.op = 2'b00; bus.srcA = 32'd10; bus.srcB = 32'd20;
`endif
    tick();
    bus.start = 1'b0;
    pulses = 0; lat = 0; data = '0;
    for (int c = 1; c <= 45; c++) begin
`ifdef EXEC_MUL_EN
      bus.start = (c == 5 || c == 33);
`else
      bus.start = (c == 1 || c == 2);
`endif
      bus.op = 2'b01; bus.dstReg = 2'd0;
      if (c == 10) bus.srcA = 32'hDEAD_BEEF;
      tick();
      if (bus.writeEnable) begin
        pulses++;
        lat = c;
        data = bus.writeData;
      end
    end
    bus.start = 1'b0;
    check("ign_pulses", 64'(pulses), 64'(1));
`ifdef EXEC_MUL_EN
    check("ign_lat",  64'(lat), 64'(33));
    check("ign_data", 64'(data), 64'(32'd3_000_000));
`else
    check("ign_lat",  64'(lat), 64'(1));
    check("ign_data", 64'(data), 64'(32'd30));
`endif
    check("ign_busy", 64'(bus.busy), 64'(1'b0));

`ifdef EXEC_MUL_EN
    bus.start = 1'b1; bus.op = 2'b11; bus.srcA = 32'd7; bus.srcB = 32'd9; bus.dstReg = 2'd1;
    tick();
    bus.start = 1'b0;
    for (int c = 0; c < 15; c++) tick();
    #2 reset = 1'b1;
    #1;
    check("mrst_busy", 64'(bus.busy), 64'(1'b0));
    check("mrst_we",   64'(bus.writeEnable), 64'(1'b0));
    @(negedge clk); reset = 1'b0;
    pulses = 0;
    for (int c = 0; c < 40; c++) begin
      tick();
      if (bus.writeEnable) pulses++;
    end
    check("mrst_no_we", 64'(pulses), 64'(0));
`endif
    run_op("add_post", 2'b00, 32'd2, 32'd3, 2'd0, 32'd5, 1'b0, 1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
